// File: rtl/btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse
//
// Conditions one raw push-button level for the digital clock. The button is
// brought into the clk domain through a two-flop synchroniser and debounced
// by a four-state FSM. The block produces a clean level plus single-cycle
// press and release pulses.
//
// Optional feature (compile-time macro BTN_AUTOREPEAT_EN):
//   While the button stays accepted as held, press_pulse fires once after
//   HOLD_CYCLES cycles. It then fires again every REPEAT_CYCLES cycles until
//   the button leaves the held state. Without the macro, exactly one
//   press_pulse is produced per accepted press.
//
// Ports:
//   clk           in   system clock (100 MHz)
//   reset         in   synchronous, active-high reset
//   btn_in        in   raw asynchronous button level, 1 = pressed
//   btn_level     out  debounced button level
//   press_pulse   out  one-cycle pulse per accepted press (plus repeats)
//   release_pulse out  one-cycle pulse per accepted release
// ---------------------------------------------------------------------------
module btn_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // Catch impossible configurations at elaboration time: a zero-length
    // debounce or a cycle count that does not fit the counter.
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        (64'(DEBOUNCE_CYCLES) >> CNT_W) != 64'd0 ||
        (64'(HOLD_CYCLES) >> CNT_W) != 64'd0 ||
        (64'(REPEAT_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_param
        $error("btn_debounce_pulse: cycle parameters must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             sync_meta_q, sync_meta_d;
    logic             btn_sync_q, btn_sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             repeating_q, repeating_d;
    logic             repeat_fire;
`endif

    // All state registers. Reset wins over everything else on the same edge,
    // including the synchroniser, so a partially counted debounce is simply
    // forgotten and a button still held afterwards starts from scratch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            sync_meta_q     <= 1'b0;
            btn_sync_q      <= 1'b0;
            cnt_q           <= '0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            hold_cnt_q      <= '0;
            repeating_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            sync_meta_q     <= sync_meta_d;
            btn_sync_q      <= btn_sync_d;
            cnt_q           <= cnt_d;
            btn_level_q     <= btn_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
`ifdef BTN_AUTOREPEAT_EN
            hold_cnt_q      <= hold_cnt_d;
            repeating_q     <= repeating_d;
`endif
        end
    end

    // Two-flop synchroniser; only btn_sync_q is visible to the FSM.
    always_comb begin
        sync_meta_d = btn_in;
        btn_sync_d  = sync_meta_q;
    end

`ifdef BTN_AUTOREPEAT_EN
    // Hold/repeat timer. It only advances while the FSM sits in HELD with the
    // button still high. In every other case it is zero, so any entry into
    // HELD (fresh press or return after a release bounce) starts from zero.
    // The first pulse waits HOLD_CYCLES; later ones wait REPEAT_CYCLES.
    // A low sample in HELD takes priority, so leaving HELD never fires.
    always_comb begin
        hold_cnt_d  = '0;
        repeating_d = 1'b0;
        repeat_fire = 1'b0;
        if (state_q == HELD && btn_sync_q) begin
            repeating_d = repeating_q;
            if ((!repeating_q && hold_cnt_q == HOLD_LAST) ||
                ( repeating_q && hold_cnt_q == REPEAT_LAST)) begin
                repeat_fire = 1'b1;
                repeating_d = 1'b1;
                hold_cnt_d  = '0;
            end else begin
                hold_cnt_d  = hold_cnt_q + CNT_ONE;
            end
        end
    end
`endif

    // Debounce FSM. The counter holds the number of consecutive samples of
    // the candidate level seen so far, starting at 1 on the sample that left
    // the stable state. The transition is taken on the sample after the
    // count reaches DEBOUNCE_CYCLES, and only if the level is still there.
    // The count therefore never passes DEBOUNCE_CYCLES.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        btn_level_d     = btn_level_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                btn_level_d = 1'b0;
                cnt_d       = '0;
                if (btn_sync_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!btn_sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_TERM) begin
                    state_d       = HELD;
                    cnt_d         = '0;
                    btn_level_d   = 1'b1;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            HELD: begin
                btn_level_d = 1'b1;
                cnt_d       = '0;
                if (!btn_sync_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end

            RELEASE_WAIT: begin
                if (btn_sync_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_TERM) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    btn_level_d     = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                btn_level_d = 1'b0;
            end
        endcase

`ifdef BTN_AUTOREPEAT_EN
        // Repeats only occur in HELD. The debounce press pulse only occurs
        // in PRESS_WAIT and the release pulse only in RELEASE_WAIT, so the
        // OR can never overlap a release.
        if (repeat_fire) begin
            press_pulse_d = 1'b1;
        end
`endif
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_pulse
//
// Directed bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=20 and REPEAT_CYCLES=8. Cycle k is the output seen 1 ns after
// the k-th rising edge. Edge 0 is the first edge that samples a new btn_in
// level. Expected values are hand-derived pulse positions. Build with
// +define+BTN_AUTOREPEAT_EN to add the auto-repeat scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_debounce_pulse;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    int comps = 0;
    int errs  = 0;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8),
        .CNT_W          (26)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset held for 3 cycles while btn_in toggles, then one cycle after
    // release. All outputs must stay low throughout.
    task automatic test_reset();
        reset  = 1'b1;
        btn_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            btn_in = ~btn_in;
            next_cycle();
            comps++;
            if (btn_level !== 1'b0) begin
                errs++;
                $display("[TB] FAIL reset_level k=%0d got %b want 0", k, btn_level);
            end
            comps++;
            if (press_pulse !== 1'b0) begin
                errs++;
                $display("[TB] FAIL reset_press k=%0d got %b want 0", k, press_pulse);
            end
            comps++;
            if (release_pulse !== 1'b0) begin
                errs++;
                $display("[TB] FAIL reset_release k=%0d got %b want 0", k, release_pulse);
            end
        end
        reset  = 1'b0;
        btn_in = 1'b0;
        next_cycle();
        comps++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            errs++;
            $display("[TB] FAIL post_reset got %b want 000",
                     {btn_level, press_pulse, release_pulse});
        end
        for (int k = 0; k < 6; k++) next_cycle();
    endtask

    // Bounce pattern: 3 cycles high, 1 low, for 32 cycles, then low.
    // The debounce count never gets past 3, so nothing is accepted.
    task automatic test_bounce();
        for (int k = 0; k < 42; k++) begin
            btn_in = (k < 32) && ((k % 4) != 3);
            next_cycle();
            comps++;
            if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
                errs++;
                $display("[TB] FAIL bounce k=%0d got %b want 000",
                         k, {btn_level, press_pulse, release_pulse});
            end
        end
    endtask

    // Reset pulsed on edge 4 while still in PRESS_WAIT. There must be no
    // pulse before it. The press is then accepted 6 cycles after the first
    // edge following reset deassertion.
    task automatic test_reset_mid();
        btn_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            comps++;
            if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
                errs++;
                $display("[TB] FAIL pre_reset k=%0d got %b want 000",
                         k, {btn_level, press_pulse, release_pulse});
            end
        end
        reset = 1'b1;
        next_cycle();
        comps++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            errs++;
            $display("[TB] FAIL mid_reset got %b want 000",
                     {btn_level, press_pulse, release_pulse});
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            comps++;
            if (press_pulse !== (k == 6)) begin
                errs++;
                $display("[TB] FAIL rmid_press k=%0d got %b want %b", k, press_pulse, k == 6);
            end
            comps++;
            if (btn_level !== (k >= 6)) begin
                errs++;
                $display("[TB] FAIL rmid_level k=%0d got %b want %b", k, btn_level, k >= 6);
            end
        end
        btn_in = 1'b0;
        for (int k = 0; k < 12; k++) next_cycle();
    endtask

    // Press held 40 cycles: one press pulse at cycle 6. With auto-repeat,
    // repeats also appear at cycles 26 and 34.
    task automatic test_press();
        logic want_press;
        btn_in = 1'b1;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            want_press = (k == 6);
`ifdef BTN_AUTOREPEAT_EN
            want_press = want_press || (k == 26) || (k == 34);
`endif
            comps++;
            if (press_pulse !== want_press) begin
                errs++;
                $display("[TB] FAIL press k=%0d got %b want %b", k, press_pulse, want_press);
            end
            comps++;
            if (btn_level !== (k >= 6)) begin
                errs++;
                $display("[TB] FAIL press_level k=%0d got %b want %b", k, btn_level, k >= 6);
            end
            comps++;
            if (release_pulse !== 1'b0) begin
                errs++;
                $display("[TB] FAIL press_release k=%0d got %b want 0", k, release_pulse);
            end
        end
    endtask

    // Two-cycle low glitch while held: no pulse, level stays high.
    task automatic test_glitch();
        for (int k = 0; k < 12; k++) begin
            btn_in = (k >= 2);
            next_cycle();
            comps++;
            if ({btn_level, press_pulse, release_pulse} !== 3'b100) begin
                errs++;
                $display("[TB] FAIL glitch k=%0d got %b want 100",
                         k, {btn_level, press_pulse, release_pulse});
            end
        end
    endtask

    // Release from HELD: release pulse at cycle 6, level low from cycle 6.
    task automatic test_release();
        btn_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            comps++;
            if (release_pulse !== (k == 6)) begin
                errs++;
                $display("[TB] FAIL release k=%0d got %b want %b", k, release_pulse, k == 6);
            end
            comps++;
            if (btn_level !== (k < 6)) begin
                errs++;
                $display("[TB] FAIL release_level k=%0d got %b want %b", k, btn_level, k < 6);
            end
            comps++;
            if (press_pulse !== 1'b0) begin
                errs++;
                $display("[TB] FAIL release_press k=%0d got %b want 0", k, press_pulse);
            end
        end
    endtask

`ifdef BTN_AUTOREPEAT_EN
    // Held 60 cycles then released. Expect presses at 6, 26, 34, 42, 50 and
    // 58, and a release at 66 with no press there.
    task automatic test_autorepeat();
        logic want_press;
        for (int k = 0; k < 72; k++) begin
            btn_in = (k < 60);
            next_cycle();
            want_press = (k == 6) || (k == 26) || (k == 34) ||
                         (k == 42) || (k == 50) || (k == 58);
            comps++;
            if (press_pulse !== want_press) begin
                errs++;
                $display("[TB] FAIL arep_press k=%0d got %b want %b", k, press_pulse, want_press);
            end
            comps++;
            if (release_pulse !== (k == 66)) begin
                errs++;
                $display("[TB] FAIL arep_release k=%0d got %b want %b", k, release_pulse, k == 66);
            end
            comps++;
            if (btn_level !== (k >= 6 && k < 66)) begin
                errs++;
                $display("[TB] FAIL arep_level k=%0d got %b want %b",
                         k, btn_level, (k >= 6 && k < 66));
            end
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;
        test_reset();
        test_bounce();
        test_reset_mid();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`endif
        test_press();
        test_glitch();
        test_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
        $finish;
    end

endmodule
